// File: rtl/multiply_mult_pipe_if.sv
// Handshake bundle for the floating-point multiply stage: upstream operands in,
// unbiased exponent / mantissa product out.
interface multiply_mult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int TAG_W = 4
);
    localparam int OP_W   = 1 + EXP_W + MAN_W;
    localparam int PROD_W = 2 * MAN_W + 2;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a_in;
    logic [OP_W-1:0]   b_in;
    logic [OP_W-1:0]   z_in;
    logic              idle_in;
    logic [TAG_W-1:0]  tag_in;
    logic              out_valid;
    logic              out_ready;
    logic              idle_out;
    logic [OP_W-1:0]   z_out;
    logic [PROD_W-1:0] product_out;
    logic              exp_ovf_out;
    logic [TAG_W-1:0]  tag_out;

    modport slave (
        input  in_valid, a_in, b_in, z_in, idle_in, tag_in, out_ready,
        output in_ready, out_valid, idle_out, z_out, product_out, exp_ovf_out, tag_out
    );

    modport master (
        output in_valid, a_in, b_in, z_in, idle_in, tag_in, out_ready,
        input  in_ready, out_valid, idle_out, z_out, product_out, exp_ovf_out, tag_out
    );
endinterface

// File: rtl/multiply_mult_pipe.sv
// Elastic multiply stage: exponent add and full mantissa product in stage 1,
// followed by DEPTH-1 register stages with per-stage valid/ready and bubble collapsing.
module multiply_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24,
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    multiply_mult_pipe_if.slave bus
);
    localparam int OP_W   = 1 + EXP_W + MAN_W;
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EXP_W+1:0] EXP_OFS = (EXP_W + 2)'(1 - 2 * BIAS);
    localparam logic signed [EXP_W+1:0] EXP_MIN = (EXP_W + 2)'(-(1 << (EXP_W - 1)));
    localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W + 2)'((1 << (EXP_W - 1)) - 1);

    function automatic logic signed [EXP_W+1:0] exp_sum(input logic [EXP_W-1:0] ea,
                                                       input logic [EXP_W-1:0] eb);
        return $signed({2'b00, ea}) + $signed({2'b00, eb}) + EXP_OFS;
    endfunction

    function automatic logic exp_out_of_range(input logic signed [EXP_W+1:0] sum);
        return (sum < EXP_MIN) || (sum > EXP_MAX);
    endfunction

    logic                      s1_sign;
    logic signed [EXP_W+1:0]   s1_exp;
    logic [OP_W-1:0]           s1_z;
    logic [PROD_W-1:0]         s1_prod;
    logic                      s1_ovf;

    logic [DEPTH-1:0]  vld_q, vld_d, idle_q, idle_d, ovf_q, ovf_d;
    logic [OP_W-1:0]   z_q    [DEPTH];
    logic [OP_W-1:0]   z_d    [DEPTH];
    logic [PROD_W-1:0] prod_q [DEPTH];
    logic [PROD_W-1:0] prod_d [DEPTH];
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [DEPTH-1:0]  rdy;
    logic              rdy_acc;

    always_comb begin
        s1_sign = bus.a_in[OP_W-1] ^ bus.b_in[OP_W-1];
        s1_exp  = exp_sum(bus.a_in[OP_W-2 -: EXP_W], bus.b_in[OP_W-2 -: EXP_W]);
        if (bus.idle_in) begin
            s1_z    = bus.z_in;
            s1_prod = '0;
            s1_ovf  = 1'b0;
        end else begin
            s1_z    = {s1_sign, s1_exp[EXP_W-1:0], {MAN_W{1'b0}}};
            // Widen before multiplying so no product bits are lost.
            s1_prod = {{MAN_W{1'b0}}, bus.a_in[MAN_W-1:0]} * {{MAN_W{1'b0}}, bus.b_in[MAN_W-1:0]}
                      << 2;
            s1_ovf  = exp_out_of_range(s1_exp);
        end
    end

    // A stage may advance when it is empty or anything downstream of it can drain.
    always_comb begin
        rdy_acc = bus.out_ready;
        rdy     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_acc = rdy_acc | ~vld_q[k];
            rdy[k]  = rdy_acc;
        end
    end

    always_comb begin
        vld_d  = vld_q;
        idle_d = idle_q;
        ovf_d  = ovf_q;
        z_d    = z_q;
        prod_d = prod_q;
        tag_d  = tag_q;
        // stage 1: compute
        if (rdy[0]) begin
            vld_d[0] = bus.in_valid;
            if (bus.in_valid) begin
                idle_d[0] = bus.idle_in;
                ovf_d[0]  = s1_ovf;
                z_d[0]    = s1_z;
                prod_d[0] = s1_prod;
                tag_d[0]  = bus.tag_in;
            end
        end
        // stages 2..DEPTH: retiming registers
        for (int k = 1; k < DEPTH; k++) begin
            if (rdy[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    idle_d[k] = idle_q[k-1];
                    ovf_d[k]  = ovf_q[k-1];
                    z_d[k]    = z_q[k-1];
                    prod_d[k] = prod_q[k-1];
                    tag_d[k]  = tag_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q  <= '0;
            idle_q <= '0;
            ovf_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                z_q[k]    <= '0;
                prod_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            idle_q <= idle_d;
            ovf_q  <= ovf_d;
            z_q    <= z_d;
            prod_q <= prod_d;
            tag_q  <= tag_d;
        end
    end

    assign bus.in_ready    = rdy[0];
    assign bus.out_valid   = vld_q[DEPTH-1];
    assign bus.idle_out    = idle_q[DEPTH-1];
    assign bus.exp_ovf_out = ovf_q[DEPTH-1];
    assign bus.z_out       = z_q[DEPTH-1];
    assign bus.product_out = prod_q[DEPTH-1];
    assign bus.tag_out     = tag_q[DEPTH-1];
endmodule

// File: tb/tb_multiply_mult_pipe.sv
// Randomised scoreboard bench for multiply_mult_pipe with directed corner cases,
// stall stability and mid-flight reset.
module tb_multiply_mult_pipe;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 24;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 4;
    localparam int OP_W   = 1 + EXP_W + MAN_W;
    localparam int PROD_W = 2 * MAN_W + 2;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiply_mult_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

    multiply_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int emitted  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [OP_W-1:0]   z;
        logic [PROD_W-1:0] p;
        logic              ovf;
        logic              idle;
        logic [TAG_W-1:0]  tag;
    } item_t;

    item_t exp_q[$];
    item_t got_e;

    // Reference: real-valued exponent rule and plain integer mantissa multiply.
    function automatic item_t model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                    input logic [OP_W-1:0] z, input logic idle,
                                    input logic [TAG_W-1:0] tag);
        item_t r;
        int e;
        longint unsigned ma, mb;
        r.tag  = tag;
        r.idle = idle;
        if (idle) begin
            r.z   = z;
            r.p   = '0;
            r.ovf = 1'b0;
        end else begin
            e     = (int'(a[OP_W-2 -: EXP_W]) - BIAS) + (int'(b[OP_W-2 -: EXP_W]) - BIAS) + 1;
            r.ovf = (e < -(1 << (EXP_W - 1))) || (e > (1 << (EXP_W - 1)) - 1);
            ma    = 64'(a[MAN_W-1:0]);
            mb    = 64'(b[MAN_W-1:0]);
            r.p   = PROD_W'(ma * mb * 64'd4);
            r.z   = {a[OP_W-1] ^ b[OP_W-1], EXP_W'(e), {MAN_W{1'b0}}};
        end
        return r;
    endfunction

    logic              prev_stall = 1'b0;
    logic [OP_W-1:0]   prev_z;
    logic [PROD_W-1:0] prev_p;
    logic [TAG_W-1:0]  prev_tag;
    logic              prev_idle, prev_ovf;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(bus.out_valid), 64'd1);
                check_eq("stall_z", 64'(bus.z_out), 64'(prev_z));
                check_eq("stall_prod", 64'(bus.product_out), 64'(prev_p));
                check_eq("stall_tag", 64'(bus.tag_out), 64'(prev_tag));
                check_eq("stall_flags", 64'({bus.idle_out, bus.exp_ovf_out}),
                         64'({prev_idle, prev_ovf}));
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.a_in, bus.b_in, bus.z_in, bus.idle_in, bus.tag_in));
            if (bus.out_valid && bus.out_ready) begin
                check_eq("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    got_e = exp_q.pop_front();
                    check_eq("out_z", 64'(bus.z_out), 64'(got_e.z));
                    check_eq("out_prod", 64'(bus.product_out), 64'(got_e.p));
                    check_eq("out_ovf", 64'(bus.exp_ovf_out), 64'(got_e.ovf));
                    check_eq("out_idle", 64'(bus.idle_out), 64'(got_e.idle));
                    check_eq("out_tag", 64'(bus.tag_out), 64'(got_e.tag));
                    emitted++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_z     = bus.z_out;
            prev_p     = bus.product_out;
            prev_tag   = bus.tag_out;
            prev_idle  = bus.idle_out;
            prev_ovf   = bus.exp_ovf_out;
        end
    end

    // Presents one item and returns just after the edge that accepted it, in_valid still high.
    task automatic send_item(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                             input logic [OP_W-1:0] z, input logic idle,
                             input logic [TAG_W-1:0] tag);
        logic ok;
        int   n;
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        bus.z_in     = z;
        bus.idle_in  = idle;
        bus.tag_in   = tag;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic directed(input string name, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                            input logic [OP_W-1:0] z, input logic idle, input logic [TAG_W-1:0] tag,
                            input logic [OP_W-1:0] ez, input logic [PROD_W-1:0] ep,
                            input logic eo);
        bus.out_ready = 1'b1;
        send_item(a, b, z, idle, tag);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_eq({name, "_latency"}, 64'(bus.out_valid), 64'(DEPTH == 1));
        repeat (DEPTH - 1) @(negedge clk);
        check_eq({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_eq({name, "_z"}, 64'(bus.z_out), 64'(ez));
        check_eq({name, "_prod"}, 64'(bus.product_out), 64'(ep));
        check_eq({name, "_ovf"}, 64'(bus.exp_ovf_out), 64'(eo));
        check_eq({name, "_idle"}, 64'(bus.idle_out), 64'(idle));
        check_eq({name, "_tag"}, 64'(bus.tag_out), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        return OP_W'({$urandom, $urandom});
    endfunction

    logic sending;
    logic saw_block;
    int   base;

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.z_in      = '0;
        bus.idle_in   = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_z", 64'(bus.z_out), 64'd0);
        check_eq("rst_prod", 64'(bus.product_out), 64'd0);
        check_eq("rst_flags", 64'({bus.idle_out, bus.exp_ovf_out}), 64'd0);
        check_eq("rst_tag", 64'(bus.tag_out), 64'd0);
        @(posedge clk);
        #1;

        directed("mul_2x3", 33'h0_8080_0000, 33'h0_80C0_0000, '0, 1'b0, 4'd5,
                 33'h0_0300_0000, 50'h1800000000000, 1'b0);
        directed("mul_neg_half", 33'h1_7E80_0000, 33'h0_7E80_0000, '0, 1'b0, 4'd9,
                 33'h1_FF00_0000, 50'h1000000000000, 1'b0);
        directed("exp_ovf_hi", 33'h0_FF80_0000, 33'h0_FF80_0000, '0, 1'b0, 4'd1,
                 33'h0_0100_0000, 50'h1000000000000, 1'b1);
        directed("exp_ovf_lo", 33'h0_00C0_0000, 33'h1_00FF_FFFF, '0, 1'b0, 4'd2,
                 33'h1_0300_0000, 50'h2FFFFFD000000, 1'b1);
        directed("idle_bypass", 33'h0_1234_5678, 33'h1_ABCD_EF01, 33'h1_7F80_0000, 1'b1, 4'd3,
                 33'h1_7F80_0000, 50'h0, 1'b0);

        // Six back-to-back items with the sink stalled for four cycles.
        base      = emitted;
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_item(rand_op(), rand_op(), rand_op(), 1'b0, TAG_W'(i + 8));
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 10; c++) begin
                    bus.out_ready = !(c >= 3 && c <= 6);
                    @(negedge clk);
                    if (!bus.out_ready && !bus.in_ready) saw_block = 1'b1;
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        check_eq("stall_in_ready_low", 64'(saw_block), 64'd1);
        check_eq("stall_all_emerged", 64'(emitted - base), 64'd6);

        // Randomised traffic with random gaps and random backpressure.
        sending = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_item(rand_op(), rand_op(), rand_op(), ($urandom_range(0, 7) == 0),
                              TAG_W'($urandom));
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                bus.in_valid = 1'b0;
                sending = 1'b0;
            end
            begin
                while (sending) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();

        // Reset while two items are held: neither may ever appear.
        bus.out_ready = 1'b0;
        send_item(33'h0_8080_0000, 33'h0_80C0_0000, '0, 1'b0, 4'd6);
        send_item(33'h0_7F80_0000, 33'h0_7F80_0000, '0, 1'b0, 4'd7);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        base = emitted;
        @(negedge clk);
        check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("flush_z", 64'(bus.z_out), 64'd0);
        check_eq("flush_prod", 64'(bus.product_out), 64'd0);
        check_eq("flush_tag_flags", 64'({bus.tag_out, bus.idle_out, bus.exp_ovf_out}), 64'd0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("flush_none_emitted", 64'(emitted - base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
